// File: rtl/adc_driver_if.sv
// Pin bundle between adc_driver and an AD7606-class parallel ADC.
// master: the controller side (adc_driver). slave: the ADC / board side.
// DB is the ADC's data bus; the controller only ever listens to it, so it
// appears as an input on the master modport and is never driven from there.
interface adc_driver_if;
  logic        Busy;
  logic [15:0] DB;
  logic        convst_A;
  logic        convst_B;
  logic        convst_C;
  logic        convst_D;
  logic        read;
  logic        CS;
  logic        HW;
  logic        PAR;
  logic        adc_rst;
  logic        STBY;
  logic        write;
  logic [15:0] toMem;
  logic [2:0]  ch_idx;

  modport master (
    input  Busy, DB,
    output convst_A, convst_B, convst_C, convst_D,
    output read, CS, HW, PAR, adc_rst, STBY,
    output write, toMem, ch_idx
  );

  modport slave (
    output Busy, DB,
    input  convst_A, convst_B, convst_C, convst_D,
    input  read, CS, HW, PAR, adc_rst, STBY,
    input  write, toMem, ch_idx
  );
endinterface

// File: rtl/adc_driver.sv
// Free-running controller for an AD7606-class 8-channel ADC on its parallel
// interface: resets the ADC, pulses CONVST, waits out BUSY, then reads N_CH
// words and hands each one to the sample memory with a channel index.
//
// Memory-side strobe: write is a qualifier with no back-pressure. While it is
// high the ADC is presenting a word on DB; on the clock edge that ends the
// high window the word lands in toMem and its channel in ch_idx, and both
// hold until the next such edge. The memory must accept every word.
//
// Debug: state exposes the FSM encoding
//   0 POR, 1 CONV, 2 WAIT_HI, 3 WAIT_LO, 4 READ, 5 GAP.
module adc_driver #(
  parameter int N_CH     = 8,
  parameter int RST_CYC  = 5,
  parameter int CONV_LOW = 2,
  parameter int RD_LOW   = 3,
  parameter int RD_HIGH  = 2,
  parameter int GAP      = 4,
  parameter int BUSY_TO  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  adc_driver_if.master  bus,
  output logic [2:0]    state
);

  localparam logic [2:0] POR     = 3'd0;
  localparam logic [2:0] CONV    = 3'd1;
  localparam logic [2:0] WAIT_HI = 3'd2;
  localparam logic [2:0] WAIT_LO = 3'd3;
  localparam logic [2:0] READ    = 3'd4;
  localparam logic [2:0] GAP_ST  = 3'd5;

  // Terminal values of the shared cycle counter for each timed phase.
  localparam logic [7:0] RST_LAST  = 8'(RST_CYC - 1);
  localparam logic [7:0] CONV_LAST = 8'(CONV_LOW - 1);
  localparam logic [7:0] RDL_LAST  = 8'(RD_LOW - 1);
  localparam logic [7:0] RDH_LAST  = 8'(RD_HIGH - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP - 1);
  localparam logic [7:0] BUSY_LAST = 8'(BUSY_TO - 1);
  localparam logic [2:0] WORD_LAST = 3'(N_CH - 1);

  logic [1:0] busy_meta;
  logic       busy_s;
  logic [7:0] cnt;
  logic [2:0] wcnt;
  logic       convst;

  // Fixed-level mode pins: word-wide parallel hardware mode, never standby.
  assign bus.HW   = 1'b0;
  assign bus.PAR  = 1'b0;
  assign bus.STBY = 1'b1;

  // All four conversion-start pins fire together (simultaneous sampling).
  assign bus.convst_A = convst;
  assign bus.convst_B = convst;
  assign bus.convst_C = convst;
  assign bus.convst_D = convst;

  // Two-flop synchronizer for the asynchronous BUSY pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_meta <= 2'b00;
    end else begin
      busy_meta <= {busy_meta[0], bus.Busy};
    end
  end

  assign busy_s = busy_meta[1];

  // Conversion/readout sequencer; every ADC pin and the memory port are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= POR;
      cnt         <= 8'd0;
      wcnt        <= 3'd0;
      convst      <= 1'b1;
      bus.read    <= 1'b1;
      bus.CS      <= 1'b1;
      bus.write   <= 1'b0;
      bus.toMem   <= 16'd0;
      bus.ch_idx  <= 3'd0;
      bus.adc_rst <= 1'b1;
    end else begin
      case (state)
        POR: begin
          if (cnt == RST_LAST) begin
            bus.adc_rst <= 1'b0;
            convst      <= 1'b0;
            cnt         <= 8'd0;
            state       <= CONV;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        CONV: begin
          if (cnt == CONV_LAST) begin
            convst <= 1'b1;
            cnt    <= 8'd0;
            state  <= WAIT_HI;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        WAIT_HI: begin
          // A conversion that never reports BUSY is abandoned and re-issued.
          if (busy_s) begin
            cnt   <= 8'd0;
            state <= WAIT_LO;
          end else if (cnt == BUSY_LAST) begin
            convst <= 1'b0;
            cnt    <= 8'd0;
            state  <= CONV;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        WAIT_LO: begin
          if (!busy_s) begin
            bus.CS    <= 1'b0;
            bus.read  <= 1'b0;
            bus.write <= 1'b1;
            wcnt      <= 3'd0;
            cnt       <= 8'd0;
            state     <= READ;
          end
        end
        READ: begin
          // The registered RD level doubles as the low/high phase marker.
          if (!bus.read) begin
            if (cnt == RDL_LAST) begin
              bus.toMem  <= bus.DB;
              bus.ch_idx <= wcnt;
              bus.read   <= 1'b1;
              bus.write  <= 1'b0;
              cnt        <= 8'd0;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end else begin
            if (cnt == RDH_LAST) begin
              cnt <= 8'd0;
              if (wcnt == WORD_LAST) begin
                bus.CS <= 1'b1;
                state  <= GAP_ST;
              end else begin
                wcnt      <= wcnt + 3'd1;
                bus.read  <= 1'b0;
                bus.write <= 1'b1;
              end
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        GAP_ST: begin
          if (cnt == GAP_LAST) begin
            convst <= 1'b0;
            cnt    <= 8'd0;
            state  <= CONV;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state <= POR;
          cnt   <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_driver.sv
// Bench for adc_driver: an ADC-side responder places a word on DB at the start
// of each RD-low window and records {channel, word} in an expected queue; every
// capture is compared against the queue. Directed sequences cover reset, the
// BUSY timeout, BUSY glitches during readout, mid-read reset and back-to-back
// conversions; a randomized loop varies BUSY width and data.
module tb_adc_driver;
  localparam int N_CH     = 8;
  localparam int RST_CYC  = 5;
  localparam int CONV_LOW = 2;
  localparam int GAP      = 4;
  localparam int BUSY_TO  = 16;
  localparam int RD_LOW   = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] state;

  adc_driver_if bus();

  adc_driver dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .state (state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int errors   = 0;
  logic [18:0] exp_q[$];   // {ch_idx, word}
  logic [15:0] db_src[$];  // words the ADC model will present next (else random)
  int word_i = 0;
  int last_burst = 0;
  logic prev_read = 1'b1;
  logic prev_cs = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return bus.convst_A;
      1:       return bus.CS;
      default: return bus.read;
    endcase
  endfunction

  // Wait (sampling on negedges) until the chosen pin reaches val.
  task automatic wait_sig(input int which, input logic val, input int budget, input string name);
    bit ok;
    ok = (sig(which) == val);
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = (sig(which) == val);
    end
    if (!ok) fail_now(name);
  endtask

  // ADC model + protocol monitor, sampled away from the active edge.
  always @(negedge clk) begin : monitor
    logic [15:0] w;
    logic [18:0] e;
    check("stby", bus.STBY, 1);
    check("par", bus.PAR, 0);
    check("hw", bus.HW, 0);
    check("convst_b", bus.convst_B, bus.convst_A);
    check("convst_c", bus.convst_C, bus.convst_A);
    check("convst_d", bus.convst_D, bus.convst_A);
    if (bus.CS) begin
      check("read_only_with_cs", bus.read, 1);
      check("write_idle", bus.write, 0);
    end else begin
      check("write_vs_read", bus.write, !bus.read);
    end
    if (!rst_n) begin
      exp_q.delete();
      word_i = 0;
    end else begin
      if (!bus.CS && prev_cs) word_i = 0;
      if (!bus.read && prev_read && !bus.CS) begin
        w = (db_src.size() > 0) ? db_src.pop_front() : 16'($urandom_range(0, 65535));
        bus.DB = w;
        exp_q.push_back({3'(word_i), w});
      end
      if (bus.read && !prev_read && !bus.CS) begin
        if (exp_q.size() == 0) begin
          fail_now("capture_without_window");
        end else begin
          e = exp_q.pop_front();
          check("cap_word", bus.toMem, e[15:0]);
          check("cap_ch", bus.ch_idx, e[18:16]);
        end
        word_i++;
      end
      if (bus.CS && !prev_cs) begin
        last_burst = word_i;
        check("burst_len", word_i, N_CH);
      end
    end
    prev_read = bus.read;
    prev_cs   = bus.CS;
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_busy(input int n);
    bus.Busy = 1'b1;
    repeat (n) @(negedge clk);
    bus.Busy = 1'b0;
  endtask

  // Release reset just after an edge; check the ADC reset pulse and first CONVST.
  task automatic release_and_check_por(input string name);
    int hi;
    int lo;
    @(posedge clk);
    #1 rst_n = 1'b1;
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.adc_rst) hi++;
      else break;
    end
    check({name, "_adc_rst_cycles"}, hi, RST_CYC);
    check({name, "_first_convst"}, bus.convst_A, 0);
    lo = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.convst_A) break;
      lo++;
      @(negedge clk);
    end
    check({name, "_convst_low_cycles"}, lo, CONV_LOW);
  endtask

  // Let the current readout finish; check burst length and CS-high gap before CONVST.
  task automatic finish_conv(input string name);
    int g;
    wait_sig(1, 1'b0, 60, {name, "_cs_low"});
    wait_sig(1, 1'b1, 80, {name, "_cs_high"});
    g = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.convst_A) break;
      if (bus.CS) g++;
      @(negedge clk);
    end
    check({name, "_gap_cycles"}, g, GAP);
    check({name, "_words"}, last_burst, N_CH);
  endtask

  // ---------------- test sequence ----------------
  typedef struct {
    logic [15:0] db;
    logic [15:0] exp_word;
    logic [2:0]  exp_ch;
    int          exp_wr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int wr;
    int h;
    bit bad;
    bit found;

    vecs[0] = '{16'hAAA8, 16'hAAA8, 3'd0, RD_LOW};
    vecs[1] = '{16'hE38C, 16'hE38C, 3'd1, RD_LOW};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 3'd2, RD_LOW};
    vecs[3] = '{16'hFF8C, 16'hFF8C, 3'd3, RD_LOW};
    vecs[4] = '{16'hFF80, 16'hFF80, 3'd4, RD_LOW};
    vecs[5] = '{16'h0001, 16'h0001, 3'd5, RD_LOW};
    vecs[6] = '{16'h0002, 16'h0002, 3'd6, RD_LOW};
    vecs[7] = '{16'h0003, 16'h0003, 3'd7, RD_LOW};

    bus.Busy = 1'b0;
    bus.DB   = 16'd0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_convst", bus.convst_A, 1);
    check("rst_read", bus.read, 1);
    check("rst_cs", bus.CS, 1);
    check("rst_write", bus.write, 0);
    check("rst_tomem", bus.toMem, 0);
    check("rst_ch_idx", bus.ch_idx, 0);
    check("rst_adc_rst", bus.adc_rst, 1);
    check("rst_state", state, 0);

    // 1. Reset release
    release_and_check_por("t1");

    // 2. Table-driven conversion
    for (int i = 0; i < 8; i++) db_src.push_back(vecs[i].db);
    pulse_busy(2);
    for (int i = 0; i < 8; i++) begin
      wait_sig(2, 1'b0, 40, "t2_read_low");
      wr = 0;
      for (int k = 0; k < 10; k++) begin
        if (bus.read) break;
        if (bus.write) wr++;
        @(negedge clk);
      end
      check("t2_write_cycles", wr, vecs[i].exp_wr);
      check("t2_tomem", bus.toMem, vecs[i].exp_word);
      check("t2_ch_idx", bus.ch_idx, vecs[i].exp_ch);
    end
    finish_conv("t2");

    // 6. Back-to-back conversion: first word of the second burst
    db_src.push_back(16'hFFE8);
    wait_sig(0, 1'b1, 10, "t6_convst_high");
    pulse_busy(3);
    wait_sig(2, 1'b0, 40, "t6_read_low");
    wait_sig(2, 1'b1, 10, "t6_read_high");
    check("t6_tomem", bus.toMem, 16'hFFE8);
    check("t6_ch_idx", bus.ch_idx, 0);
    finish_conv("t6");

    // 5. Reset during word 3
    wait_sig(0, 1'b1, 10, "t5_convst_high");
    pulse_busy(2);
    found = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (word_i == 3 && !bus.read && !bus.CS) begin
        found = 1;
        break;
      end
    end
    if (!found) fail_now("t5_reach_word3");
    #2 rst_n = 1'b0;
    #1;
    check("t5_convst", bus.convst_A, 1);
    check("t5_read", bus.read, 1);
    check("t5_cs", bus.CS, 1);
    check("t5_write", bus.write, 0);
    check("t5_tomem", bus.toMem, 0);
    check("t5_ch_idx", bus.ch_idx, 0);
    check("t5_adc_rst", bus.adc_rst, 1);
    check("t5_state", state, 0);
    repeat (3) @(negedge clk);
    release_and_check_por("t5");

    // 3. Busy never rises: CONVST re-issued after the timeout
    h = 0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus.convst_A) break;
      h++;
      if (!bus.read || bus.write) bad = 1;
      @(negedge clk);
    end
    check("t3_timeout_cycles", h, BUSY_TO);
    check("t3_no_read", bad, 0);

    // 4. Busy glitch during READ is ignored
    wait_sig(0, 1'b1, 10, "t4_convst_high");
    pulse_busy(4);
    wait_sig(1, 1'b0, 40, "t4_cs_low");
    repeat (12) @(negedge clk);
    pulse_busy(3);
    finish_conv("t4");

    // Randomized BUSY widths and data
    for (int r = 0; r < 6; r++) begin
      wait_sig(0, 1'b1, 10, "rnd_convst_high");
      pulse_busy($urandom_range(1, 12));
      finish_conv("rnd");
    end

    check("exp_q_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule
